// File: rtl/router_sync_n_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// router_sync_n_if : bus between router FSM/FIFOs and the router synchroniser.
// Revision 1.0
// ----------------------------------------------------------------------------
interface router_sync_n_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2,
    parameter int EVT_W  = 8
);
    logic [ADDR_W-1:0]       data_in;
    logic                    detect_add;
    logic                    write_enb_reg;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       read_enb;
    logic [NUM_CH-1:0]       timeout_en;
    logic [NUM_CH-1:0]       write_enb;
    logic                    fifo_full;
    logic                    addr_err;
    logic [NUM_CH-1:0]       vld_out;
    logic [NUM_CH-1:0]       soft_reset;
    logic [NUM_CH*EVT_W-1:0] timeout_cnt;

    modport master (
        output data_in, detect_add, write_enb_reg, full, empty, read_enb, timeout_en,
        input  write_enb, fifo_full, addr_err, vld_out, soft_reset, timeout_cnt
    );

    modport slave (
        input  data_in, detect_add, write_enb_reg, full, empty, read_enb, timeout_en,
        output write_enb, fifo_full, addr_err, vld_out, soft_reset, timeout_cnt
    );
endinterface
`default_nettype wire

// File: rtl/router_sync_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// router_sync_n : address latch, FIFO write steering and per-channel read timeout.
// Revision 1.0
// ----------------------------------------------------------------------------
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30,
    parameter int EVT_W   = 8
) (
    input  logic           clock,
    input  logic           resetn,
    router_sync_n_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_err;
    logic [NUM_CH-1:0] w_full_sel;

    // Extra MSB so NUM_CH == 2**ADDR_W compares correctly
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr     <= '0;
            r_addr_err <= 1'b0;
        end else if (bus.detect_add) begin
            r_addr     <= bus.data_in;
            r_addr_err <= ({1'b0, bus.data_in} >= (ADDR_W + 1)'(NUM_CH));
        end
    end

    assign bus.addr_err  = r_addr_err;
    assign bus.fifo_full = |w_full_sel;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic             w_sel;
            logic             w_stall;
            logic [CNT_W-1:0] r_cnt;
            logic             r_pulse;
            logic [EVT_W-1:0] r_evt;

            assign w_sel               = ~r_addr_err & (r_addr == ADDR_W'(i));
            assign bus.write_enb[i]    = w_sel & bus.write_enb_reg;
            assign w_full_sel[i]       = w_sel & bus.full[i];
            assign bus.vld_out[i]      = ~bus.empty[i];
            assign w_stall             = ~bus.empty[i] & ~bus.read_enb[i] & bus.timeout_en[i];

            always_ff @(posedge clock) begin
                if (!resetn) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                    r_evt   <= '0;
                end else if (!w_stall) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b1;
                    if (r_evt != {EVT_W{1'b1}}) begin
                        r_evt <= r_evt + 1'b1;
                    end
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_pulse <= 1'b0;
                end
            end

            assign bus.soft_reset[i]                 = r_pulse;
            assign bus.timeout_cnt[i*EVT_W +: EVT_W] = r_evt;
        end
    endgenerate
endmodule
`default_nettype wire
